router_inject_ni: RTL

//  Injection network interface for one router input port. Takes a

---
 rtl/router_ni_pkg.sv | 46 ++++
 rtl/router_ni_credit_ctr.sv | 33 +++
 rtl/router_inject_ni.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/router_ni_pkg.sv
// Shared definitions for the router injection network interface: channel and
// flow-control bit offsets, FSM state type and the round-robin VC picker.
package router_ni_pkg;

    localparam int NUM_VCS         = 4;
    localparam int VC_W            = 2;
    localparam int DEF_BUF_DEPTH   = 8;
    localparam int DEF_DATA_W      = 64;

    // Channel word, bit 0 first: valid, head, tail, vc[1:0], reserved, data.
    localparam int CH_VALID   = 0;
    localparam int CH_HEAD    = 1;
    localparam int CH_TAIL    = 2;
    localparam int CH_VC_LO   = 3;
    localparam int CH_VC_HI   = 4;
    localparam int CH_RSVD    = 5;
    localparam int CH_DATA_LO = 6;
    localparam int CH_DATA_HI = CH_DATA_LO + DEF_DATA_W - 1;

    localparam int FC_VALID   = 0;
    localparam int FC_VC_LO   = 1;
    localparam int FC_VC_HI   = 2;
    localparam int FC_W       = 3;

    typedef logic [VC_W-1:0] vc_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ni_state_e;

    // First eligible VC at or after start, wrapping; returns start if none.
    function automatic vc_t rr_pick(input logic [NUM_VCS-1:0] eligible, input vc_t start);
        vc_t pick;
        vc_t idx;
        pick = start;
        for (int k = NUM_VCS - 1; k >= 0; k--) begin
            idx = start + vc_t'(k);
            if (eligible[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/router_ni_credit_ctr.sv
// Per-VC downstream credit counter: resets full, decrements on send,
// increments on credit return, and flags a return arriving while already full.
module router_ni_credit_ctr #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         overflow
);

    logic [W-1:0] count_reg;

    assign count    = count_reg;
    assign full     = (count_reg == W'(DEPTH));
    // A return cancelled by a same-cycle send never overflows.
    assign overflow = inc && !dec && full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= W'(DEPTH);
        end else if (inc && !dec && !full) begin
            count_reg <= count_reg + W'(1);
        end else if (dec && !inc && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

endmodule

// File: rtl/router_inject_ni.sv
// Injection network interface: accepts terminal flits, allocates a VC per
// packet round-robin among empty downstream buffers, and registers the channel word.
module router_inject_ni
    import router_ni_pkg::*;
#(
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_head,
    input  logic                       in_tail,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [CH_DATA_LO+DATA_W-1:0] channel_out,
    input  logic [FC_W-1:0]            flow_ctrl_in,
    output logic                       error
);

    localparam int CHAN_W = CH_DATA_LO + DATA_W;
    localparam int CRED_W = $clog2(BUF_DEPTH + 1);

    ni_state_e           state_reg, state_next;
    vc_t                 cur_vc_reg, cur_vc_next;
    vc_t                 rr_ptr_reg, rr_ptr_next;
    logic [CHAN_W-1:0]   channel_reg, channel_next;
    logic                error_reg;

    logic [CRED_W-1:0]   credit [NUM_VCS];
    logic [NUM_VCS-1:0]  eligible;
    logic [NUM_VCS-1:0]  overflow;
    logic [NUM_VCS-1:0]  credit_inc;
    logic [NUM_VCS-1:0]  credit_dec;

    vc_t                 alloc_vc;
    vc_t                 send_vc;
    vc_t                 fc_vc;
    logic                send;
    logic                proto_err;

    assign fc_vc    = flow_ctrl_in[FC_VC_HI:FC_VC_LO];
    assign alloc_vc = rr_pick(eligible, rr_ptr_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
            assign credit_inc[gi] = flow_ctrl_in[FC_VALID] && (fc_vc == vc_t'(gi));
            assign credit_dec[gi] = send && (send_vc == vc_t'(gi));

            router_ni_credit_ctr #(
                .DEPTH (BUF_DEPTH),
                .W     (CRED_W)
            ) u_credit (
                .clk      (clk),
                .reset    (reset),
                .inc      (credit_inc[gi]),
                .dec      (credit_dec[gi]),
                .count    (credit[gi]),
                .full     (eligible[gi]),
                .overflow (overflow[gi])
            );
        end
    endgenerate

    // in_ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        state_next  = state_reg;
        cur_vc_next = cur_vc_reg;
        rr_ptr_next = rr_ptr_reg;
        in_ready    = 1'b0;
        send        = 1'b0;
        send_vc     = cur_vc_reg;
        proto_err   = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = reset && (|eligible);
                if (in_valid && in_ready) begin
                    if (in_head) begin
                        send        = 1'b1;
                        send_vc     = alloc_vc;
                        cur_vc_next = alloc_vc;
                        rr_ptr_next = alloc_vc + vc_t'(1);
                        if (!in_tail) begin
                            state_next = BUSY;
                        end
                    end else begin
                        // Body/tail with no open packet is dropped.
                        proto_err = 1'b1;
                    end
                end
            end
            BUSY: begin
                in_ready = reset && (credit[cur_vc_reg] != '0);
                if (in_valid && in_ready) begin
                    send = 1'b1;
                    if (in_head) begin
                        proto_err = 1'b1;
                    end
                    if (in_tail) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        channel_next = '0;
        if (send) begin
            channel_next[CH_VALID]                       = 1'b1;
            channel_next[CH_HEAD]                        = in_head;
            channel_next[CH_TAIL]                        = in_tail;
            channel_next[CH_VC_HI:CH_VC_LO]              = send_vc;
            channel_next[CH_DATA_LO+DATA_W-1:CH_DATA_LO] = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cur_vc_reg  <= '0;
            rr_ptr_reg  <= '0;
            channel_reg <= '0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_vc_reg  <= cur_vc_next;
            rr_ptr_reg  <= rr_ptr_next;
            channel_reg <= channel_next;
            error_reg   <= error_reg | proto_err | (|overflow);
        end
    end

    assign channel_out = channel_reg;
    assign error       = error_reg;

endmodule
